// File: rtl/game_sequencer_if.sv
// Shared opcode type plus the command/plate handshake bundle for game_sequencer.
package game_sequencer_pkg;
  localparam int scene_height_p = 20;

  typedef enum logic [2:0] {
    eNop       = 3'd0,
    eMoveLeft  = 3'd1,
    eMoveRight = 3'd2,
    eMoveDown  = 3'd3,
    eRotate    = 3'd4,
    eNew       = 3'd5,
    eCommit    = 3'd6,
    eCheck     = 3'd7
  } opcode_e;
endpackage

interface game_sequencer_if #(
  parameter int height_p = game_sequencer_pkg::scene_height_p
) ();
  game_sequencer_pkg::opcode_e cmd_i;
  logic                        cmd_v_i;
  logic                        cmd_ready_o;
  logic                        pause_i;
  game_sequencer_pkg::opcode_e plate_opcode_o;
  logic                        plate_opcode_v_o;
  logic                        plate_done_i;
  logic                        plate_landed_i;
  logic [$clog2(height_p)-1:0] plate_lines_i;
  logic                        plate_lines_v_i;
  logic                        plate_lose_i;

  // Driver side: user command source and game plate model.
  modport master (
    output cmd_i, cmd_v_i, pause_i,
    input  cmd_ready_o,
    input  plate_opcode_o, plate_opcode_v_o,
    output plate_done_i, plate_landed_i, plate_lines_i, plate_lines_v_i, plate_lose_i
  );

  // Sequencer side.
  modport slave (
    input  cmd_i, cmd_v_i, pause_i,
    output cmd_ready_o,
    output plate_opcode_o, plate_opcode_v_o,
    input  plate_done_i, plate_landed_i, plate_lines_i, plate_lines_v_i, plate_lose_i
  );
endinterface

// File: rtl/game_sequencer.sv
// Game sequencer: queues user moves, generates gravity, drives the plate one
// opcode at a time, runs the lock sequence and keeps score/level/line totals.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int height_p          = scene_height_p,
  parameter int fifo_depth_p      = 4,
  parameter int gravity_init_p    = 1000,
  parameter int gravity_step_p    = 50,
  parameter int gravity_min_p     = 100,
  parameter int lines_per_level_p = 10,
  parameter int score_width_p     = 20
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  game_sequencer_if.slave          bus,
  output logic [score_width_p-1:0] score_o,
  output logic [3:0]               level_o,
  output logic [15:0]              lines_total_o,
  output logic                     busy_o,
  output logic                     game_over_o
);
  localparam int LW = $clog2(height_p);
  localparam int AW = $clog2(fifo_depth_p);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [score_width_p-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {SPAWN, IDLE, ISSUE, WAIT, COMMIT, CHECK, NEW, OVER} state_e;

  state_e                   r_state;
  opcode_e                  r_op;
  logic                     r_opv, r_sent;
  opcode_e                  r_fifo [fifo_depth_p];
  logic [AW-1:0]            r_wr, r_rd;
  logic [AW:0]              r_cnt;
  logic [31:0]              r_grav_cnt;
  logic                     r_grav_pend;
  logic [score_width_p-1:0] r_score;
  logic [3:0]               r_level;
  logic [15:0]              r_lines, r_lvl_lines;

  logic    w_full, w_empty, w_cmd_ok, w_push, w_pop, w_issue_grav, w_run, w_tick;
  int      w_period_raw, w_period;
  opcode_e w_lock_op;
  state_e  w_lock_next;
  logic [31:0] w_base, w_add;
  logic [32:0] w_score_sum;
  logic [16:0] w_lt_sum, w_ll_sum;

  assign w_full       = (r_cnt == (AW+1)'(fifo_depth_p));
  assign w_empty      = (r_cnt == '0);
  assign w_cmd_ok     = (bus.cmd_i == eMoveLeft) || (bus.cmd_i == eMoveRight) ||
                        (bus.cmd_i == eMoveDown) || (bus.cmd_i == eRotate);
  // Non-queueable opcodes are still handshaken so the producer never stalls on them.
  assign w_push       = bus.cmd_v_i && bus.cmd_ready_o && w_cmd_ok;
  assign w_issue_grav = (r_state == IDLE) && !bus.pause_i && r_grav_pend;
  assign w_pop        = (r_state == IDLE) && !bus.pause_i && !r_grav_pend && !w_empty;
  assign w_run        = !bus.pause_i && !game_over_o;

  // Period computed in signed int so a high level cannot wrap below the floor.
  assign w_period_raw = gravity_init_p - gravity_step_p * int'(r_level);
  assign w_period     = (w_period_raw < gravity_min_p) ? gravity_min_p : w_period_raw;
  // >= rather than == so a period shrink on level-up cannot strand the counter.
  assign w_tick       = (r_grav_cnt >= $unsigned(w_period - 1));

  assign bus.cmd_ready_o      = !w_full && !game_over_o;
  assign bus.plate_opcode_o   = r_op;
  assign bus.plate_opcode_v_o = r_opv;
  assign busy_o               = (r_state != IDLE) && (r_state != OVER);
  assign game_over_o          = (r_state == OVER);
  assign score_o              = r_score;
  assign level_o              = r_level;
  assign lines_total_o        = r_lines;

  // FIFO storage (no reset needed, occupancy is tracked by r_cnt).
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr] <= bus.cmd_i;
  end

  // FIFO pointers/occupancy; game over flushes everything.
  always_ff @(posedge clk_i) begin
    if (reset_i || r_state == OVER) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_ONE;
      if (w_pop)  r_rd <= r_rd + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Gravity counter; a tick while a drop is already pending is absorbed.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_grav_cnt  <= '0;
      r_grav_pend <= 1'b0;
    end else begin
      if (w_run) r_grav_cnt <= w_tick ? '0 : r_grav_cnt + 32'd1;
      if (w_issue_grav) r_grav_pend <= 1'b0;
      if (w_run && w_tick) r_grav_pend <= 1'b1;
    end
  end

  // Opcode and successor for the single-opcode states (spawn and lock steps).
  always_comb begin
    w_lock_op   = eNew;
    w_lock_next = IDLE;
    case (r_state)
      COMMIT:  begin w_lock_op = eCommit; w_lock_next = CHECK; end
      CHECK:   begin w_lock_op = eCheck;  w_lock_next = NEW;   end
      NEW:     begin w_lock_op = eNew;    w_lock_next = bus.plate_lose_i ? OVER : IDLE; end
      default: ;
    endcase
  end

  // Main FSM: one outstanding opcode, one-cycle valid pulse per issue.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= SPAWN;
      r_op    <= eNop;
      r_opv   <= 1'b0;
      r_sent  <= 1'b0;
    end else begin
      r_opv <= 1'b0;
      case (r_state)
        SPAWN, COMMIT, CHECK, NEW: begin
          if (!r_sent) begin
            r_op   <= w_lock_op;
            r_opv  <= 1'b1;
            r_sent <= 1'b1;
          end else if (bus.plate_done_i) begin
            r_sent  <= 1'b0;
            r_state <= w_lock_next;
          end
        end
        IDLE: begin
          if (w_issue_grav) begin
            r_op    <= eMoveDown;
            r_opv   <= 1'b1;
            r_state <= ISSUE;
          end else if (w_pop) begin
            r_op    <= r_fifo[r_rd];
            r_opv   <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (bus.plate_done_i) begin
            if (r_op == eMoveDown && bus.plate_lose_i)        r_state <= OVER;
            else if (r_op == eMoveDown && bus.plate_landed_i) r_state <= COMMIT;
            else                                              r_state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Score table lookup scaled by (level+1).
  always_comb begin
    w_base = 32'd0;
    if (bus.plate_lines_i >= LW'(4)) w_base = 32'd1200;
    else begin
      case (bus.plate_lines_i[1:0])
        2'd1:    w_base = 32'd40;
        2'd2:    w_base = 32'd100;
        2'd3:    w_base = 32'd300;
        default: w_base = 32'd0;
      endcase
    end
  end

  assign w_add       = w_base * (32'(r_level) + 32'd1);
  assign w_score_sum = 33'(r_score) + 33'(w_add);
  assign w_lt_sum    = 17'(r_lines) + 17'(bus.plate_lines_i);
  assign w_ll_sum    = 17'(r_lvl_lines) + 17'(bus.plate_lines_i);

  // Score, line totals and level progression, all saturating.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_score     <= '0;
      r_level     <= '0;
      r_lines     <= '0;
      r_lvl_lines <= '0;
    end else if (bus.plate_lines_v_i) begin
      r_score <= (w_score_sum > 33'(SCORE_MAX)) ? SCORE_MAX : w_score_sum[score_width_p-1:0];
      r_lines <= w_lt_sum[16] ? 16'hFFFF : w_lt_sum[15:0];
      if (w_ll_sum >= 17'(lines_per_level_p)) begin
        r_lvl_lines <= 16'(w_ll_sum - 17'(lines_per_level_p));
        r_level     <= (r_level == 4'd15) ? 4'd15 : r_level + 4'd1;
      end else begin
        r_lvl_lines <= w_ll_sum[15:0];
      end
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a small responsive plate model.
module tb_game_sequencer;
  import game_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] score;
  logic [3:0]  level;
  logic [15:0] lines_total;
  logic        busy, game_over;

  game_sequencer_if ifc ();

  game_sequencer dut (
    .clk_i(clk), .reset_i(reset), .bus(ifc.slave),
    .score_o(score), .level_o(level), .lines_total_o(lines_total),
    .busy_o(busy), .game_over_o(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  opcode_e log_op[$];
  int      log_ts[$];

  // Plate knobs set by the stimulus
  logic hold = 1'b0, land_next = 1'b0, lose_md = 1'b0, lose_new = 1'b0;
  logic [4:0] lines_next = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
  endtask

  function automatic int cnt_op(input opcode_e o);
    int c = 0;
    foreach (log_op[i]) if (log_op[i] == o) c++;
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (log_op.size() < n && k < budget) begin @(negedge clk); k++; end
    chk(tag, 32'(log_op.size() >= n), 32'd1);
  endtask

  task automatic push(input opcode_e o);
    int k = 0;
    @(negedge clk);
    ifc.cmd_i = o; ifc.cmd_v_i = 1'b1;
    while (!ifc.cmd_ready_o && k < 300) begin @(negedge clk); k++; end
    if (k == 300) chk("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    ifc.cmd_v_i = 1'b0;
  endtask

  // Lands a piece through a queued eMoveDown and returns after the following eNew.
  task automatic do_lock(input logic [4:0] n);
    int k0, k;
    land_next = 1'b1; lines_next = n;
    k0 = cnt_op(eNew);
    push(eMoveDown);
    k = 0;
    while (cnt_op(eNew) <= k0 && k < 300) begin @(negedge clk); k++; end
    chk("lock_done", 32'(cnt_op(eNew) > k0), 32'd1);
    tick(3);
  endtask

  // Interval between the 2nd and 3rd eMoveDown issued from now on.
  task automatic measure(input string tag, input int exp);
    int k0, k, t[$];
    k0 = log_op.size(); k = 0;
    while (k < 4000) begin
      @(negedge clk); k++;
      t.delete();
      for (int i = k0; i < log_op.size(); i++) if (log_op[i] == eMoveDown) t.push_back(log_ts[i]);
      if (t.size() >= 3) break;
    end
    if (t.size() >= 3) chk(tag, 32'(t[2] - t[1]), 32'(exp));
    else chk(tag, 32'(t.size()), 32'd3);
  endtask

  // Plate model: logs each pulse, answers done one cycle later unless held.
  initial begin : plate
    logic    pend;
    opcode_e cur;
    pend = 1'b0; cur = eNop;
    ifc.plate_done_i = 1'b0; ifc.plate_landed_i = 1'b0; ifc.plate_lose_i = 1'b0;
    ifc.plate_lines_i = '0; ifc.plate_lines_v_i = 1'b0;
    forever begin
      @(negedge clk);
      ifc.plate_done_i = 1'b0; ifc.plate_lines_v_i = 1'b0;
      ifc.plate_landed_i = 1'b0; ifc.plate_lose_i = 1'b0;
      if (reset) pend = 1'b0;
      else if (ifc.plate_opcode_v_o) begin
        log_op.push_back(ifc.plate_opcode_o); log_ts.push_back(cyc);
        cur = ifc.plate_opcode_o; pend = 1'b1;
      end else if (pend && !hold) begin
        pend = 1'b0;
        ifc.plate_done_i = 1'b1;
        if (cur == eMoveDown) begin
          ifc.plate_landed_i = land_next; land_next = 1'b0;
          ifc.plate_lose_i = lose_md;
        end
        if (cur == eNew) ifc.plate_lose_i = lose_new;
        if (cur == eCheck) begin ifc.plate_lines_i = lines_next; ifc.plate_lines_v_i = 1'b1; end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    reset = 1'b1;
    ifc.cmd_i = eNop; ifc.cmd_v_i = 1'b0; ifc.pause_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_opv", 32'(ifc.plate_opcode_v_o), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_lines", 32'(lines_total), 32'd0);
    chk("rst_ready", 32'(ifc.cmd_ready_o), 32'd1);
    reset = 1'b0;

    // Spawn: exactly one eNew, then idle
    wait_log(1, 50, "spawn_pulse");
    tick(10);
    chk("spawn_op", 32'(log_op[0]), 32'(eNew));
    chk("spawn_count", 32'(log_op.size()), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // FIFO fill while paused; discarded opcodes never reach the plate
    ifc.pause_i = 1'b1;
    push(eNop); push(eCommit);
    push(eMoveLeft); push(eRotate); push(eMoveRight); push(eMoveDown);
    ifc.cmd_i = eMoveLeft; ifc.cmd_v_i = 1'b1;
    chk("full_ready", 32'(ifc.cmd_ready_o), 32'd0);
    ifc.pause_i = 1'b0;
    @(negedge clk);
    chk("ready_after_pop", 32'(ifc.cmd_ready_o), 32'd1);
    @(negedge clk);
    ifc.cmd_v_i = 1'b0;
    wait_log(6, 200, "fifo_drain");
    chk("fifo_ord1", 32'(log_op[1]), 32'(eMoveLeft));
    chk("fifo_ord2", 32'(log_op[2]), 32'(eRotate));
    chk("fifo_ord3", 32'(log_op[3]), 32'(eMoveRight));
    chk("fifo_ord4", 32'(log_op[4]), 32'(eMoveDown));
    chk("fifo_ord5", 32'(log_op[5]), 32'(eMoveLeft));
    tick(5);
    chk("no_discarded", 32'(log_op.size()), 32'd6);

    // Gravity pending and a queued command both present: gravity first
    hold = 1'b1;
    push(eRotate);
    wait_log(7, 50, "hold_issue");
    push(eMoveRight);
    tick(1100);
    hold = 1'b0;
    wait_log(9, 100, "grav_pair");
    chk("grav_first", 32'(log_op[7]), 32'(eMoveDown));
    chk("cmd_second", 32'(log_op[8]), 32'(eMoveRight));
    tick(5);

    // Landing with 4 lines at level 0
    k = log_op.size();
    do_lock(5'd4);
    chk("lock_down", 32'(log_op[k]), 32'(eMoveDown));
    chk("lock_commit", 32'(log_op[k+1]), 32'(eCommit));
    chk("lock_check", 32'(log_op[k+2]), 32'(eCheck));
    chk("lock_new", 32'(log_op[k+3]), 32'(eNew));
    chk("score_1200", 32'(score), 32'd1200);
    chk("lines_4", 32'(lines_total), 32'd4);
    chk("level_0", 32'(level), 32'd0);

    // 10 lines total -> level 1, gravity 950
    do_lock(5'd6);
    chk("score_2400", 32'(score), 32'd2400);
    chk("lines_10", 32'(lines_total), 32'd10);
    chk("level_1", 32'(level), 32'd1);
    measure("period_lvl1", 950);

    // Climb to level 15 and past it
    for (int i = 0; i < 14; i++) do_lock(5'd10);
    chk("level_15", 32'(level), 32'd15);
    chk("score_lvl15", 32'(score), 32'd145200);
    chk("lines_150", 32'(lines_total), 32'd150);
    do_lock(5'd10);
    chk("level_sat", 32'(level), 32'd15);
    chk("score_x16", 32'(score), 32'd164400);
    do_lock(5'd2);
    chk("score_two", 32'(score), 32'd166000);
    chk("lines_162", 32'(lines_total), 32'd162);
    do_lock(5'd19);
    chk("score_clip4", 32'(score), 32'd185200);
    chk("lines_181", 32'(lines_total), 32'd181);
    measure("period_lvl15", 250);

    // Lose at eNew done
    lose_new = 1'b1;
    do_lock(5'd0);
    lose_new = 1'b0;
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_ready", 32'(ifc.cmd_ready_o), 32'd0);
    chk("over_busy", 32'(busy), 32'd0);
    k = log_op.size();
    ifc.cmd_i = eMoveLeft; ifc.cmd_v_i = 1'b1;
    tick(1500);
    ifc.cmd_v_i = 1'b0;
    chk("over_silent", 32'(log_op.size()), 32'(k));
    chk("over_score_kept", 32'(score), 32'd185200);

    // Reset out of game over
    reset = 1'b1;
    tick(2);
    chk("rst2_over", 32'(game_over), 32'd0);
    chk("rst2_score", 32'(score), 32'd0);
    chk("rst2_level", 32'(level), 32'd0);
    chk("rst2_lines", 32'(lines_total), 32'd0);
    reset = 1'b0;
    wait_log(k + 1, 50, "rst2_spawn");
    tick(10);
    chk("rst2_op", 32'(log_op[k]), 32'(eNew));
    chk("rst2_count", 32'(log_op.size()), 32'(k + 1));
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_ready", 32'(ifc.cmd_ready_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter height_p, default scene_height_p, playfield rows; sets plate_lines_i width.
REQ-002 SHALL have parameter fifo_depth_p, default 4, command FIFO entries; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter gravity_init_p, default 1000, gravity period in cycles at level 0.
REQ-004 SHALL have parameter gravity_step_p, default 50, period reduction in cycles per level.
REQ-005 SHALL have parameter gravity_min_p, default 100, floor on the gravity period.
REQ-006 SHALL have parameter lines_per_level_p, default 10, cleared lines per level increment.
REQ-007 SHALL have parameter score_width_p, default 20, score counter width.
REQ-008 SHALL have port clk_i, input, 1, the single clock.
REQ-009 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-010 SHALL have port cmd_i, input, opcode_e, the user command.
REQ-011 SHALL have port cmd_v_i, input, 1, user command valid.
REQ-012 SHALL have port cmd_ready_o, output, 1, FIFO can accept a command.
REQ-013 SHALL have port pause_i, input, 1, freezes gravity and opcode issue.
REQ-014 SHALL have port plate_opcode_o, output, opcode_e, opcode to the game plate.
REQ-015 SHALL have port plate_opcode_v_o, output, 1, opcode valid.
REQ-016 SHALL have port plate_done_i, input, 1, plate finished the current opcode.
REQ-017 SHALL have port plate_landed_i, input, 1, current tile cannot move down; sampled when plate_done_i=1.
REQ-018 SHALL have port plate_lines_i, input, $clog2(height_p), lines eliminated.
REQ-019 SHALL have port plate_lines_v_i, input, 1, plate_lines_i valid.
REQ-020 SHALL have port plate_lose_i, input, 1, plate lose flag.
REQ-021 SHALL have output ports score_o [score_width_p], level_o [4], lines_total_o [16], busy_o [1] and game_over_o [1].

Function
REQ-022 SHALL, under cmd_v_i && cmd_ready_o, accept eMoveLeft, eMoveRight, eMoveDown and eRotate into the FIFO, and SHALL accept and discard all other opcodes.
REQ-023 SHALL drive cmd_ready_o = !full && !game_over_o; the producer holds cmd_i until it is accepted.
REQ-024 SHALL compute gravity period = max(gravity_init_p - level_o*gravity_step_p, gravity_min_p) with signed-safe arithmetic, i.e. no underflow.
REQ-025 SHALL run a gravity counter that holds while pause_i=1 or game_over_o=1; at period-1 it wraps to 0 and sets gravity_pending; a further tick while pending is absorbed.
REQ-026 SHALL use FSM states SPAWN, IDLE, ISSUE, WAIT, COMMIT, CHECK, NEW, OVER.
REQ-027 SHALL, in SPAWN (the first state after reset), issue eNew, and on completion go to IDLE.
REQ-028 SHALL, in IDLE with pause_i=0, issue eMoveDown if gravity_pending (clearing the flag), otherwise pop the FIFO head if it is non-empty; gravity wins when both are pending.
REQ-029 SHALL issue an opcode by asserting plate_opcode_v_o for exactly 1 cycle with plate_opcode_o stable, then wait in WAIT for plate_done_i; only one opcode is ever outstanding.
REQ-030 SHALL go to OVER when plate_done_i=1 for eMoveDown with plate_lose_i=1.
REQ-031 SHALL, when plate_done_i=1 for eMoveDown with plate_landed_i=1 and plate_lose_i=0, run the lock sequence COMMIT(eCommit) -> CHECK(eCheck) -> NEW(eNew), waiting for done after each; pause_i does not interrupt the sequence.
REQ-032 SHALL otherwise return to IDLE after done.
REQ-033 SHALL go to OVER after NEW's done if plate_lose_i=1, otherwise to IDLE.
REQ-034 SHALL, in OVER, assert game_over_o=1, flush the FIFO and issue nothing; OVER exits only via reset.
REQ-035 SHALL, on plate_lines_v_i with n=plate_lines_i, add {0,40,100,300,1200}[min(n,4)]*(level_o+1) to score_o, saturating at all-ones.
REQ-036 SHALL, on plate_lines_v_i, add n to lines_total_o (saturating at 16'hFFFF) and to an in-level counter; when the in-level counter reaches or exceeds lines_per_level_p, subtract lines_per_level_p from it and increment level_o, saturating at 15.
REQ-037 SHALL drive busy_o=1 in every state except IDLE and OVER.

Reset
REQ-038 SHALL, on reset_i, clear the FIFO, gravity counter, gravity_pending, score_o, level_o, lines_total_o and the in-level counter, drive plate_opcode_v_o=0 and game_over_o=0, and enter SPAWN, including when reset occurs mid-operation.

Verification
REQ-039 SHALL be covered by: reset -> exactly one eNew pulse; done returned -> IDLE, busy_o=0.
REQ-040 SHALL be covered by: FIFO full with 4 commands, cmd_v_i held -> cmd_ready_o=0; a command is accepted on the cycle after the first pop; order preserved.
REQ-041 SHALL be covered by: gravity_pending and a FIFO command both present -> eMoveDown issued first, then the command.
REQ-042 SHALL be covered by: eMoveDown done with landed=1, then lines=4 at level 0 -> eCommit, eCheck, eNew issued in order; score_o=1200 and lines_total_o=4.
REQ-043 SHALL be covered by: 10 lines cleared -> level_o=1 and gravity period 950; at level 15 the period is max(250,100)=250.
REQ-044 SHALL be covered by: plate_lose_i=1 at eNew done -> game_over_o=1, cmd_ready_o=0, no further pulses until reset.
